pin_teclado: RTL and testbench

PIN_TECLADO -- requirements
Module: pin_teclado

---
 rtl/pin_teclado_pkg.sv | 28 ++
 rtl/pin_teclado_temporizador.sv | 44 ++++
 rtl/pin_teclado.sv | 147 ++++++++++++++
 tb/tb_pin_teclado.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/pin_teclado_pkg.sv
// ----------------------------------------------------------------------------
// pin_teclado_pkg
// Shared definitions for the PIN keypad entry block and the gate controller:
// key codes, FSM state encoding and the "no entry" PIN value.
// ----------------------------------------------------------------------------
package pin_teclado_pkg;

   localparam logic [3:0] TECLA_BORRAR = 4'hA;
   localparam logic [3:0] TECLA_ENVIAR = 4'hB;
   localparam logic [7:0] PIN_ESPERA   = 8'h00;

   typedef enum logic [1:0] {
      ESPERA   = 2'd0,
      DIGITO1  = 2'd1,
      COMPLETO = 2'd2,
      ENVIO    = 2'd3
   } estado_t;

   function automatic logic es_digito(input logic [3:0] t);
      return (t <= 4'h9);
   endfunction

   // Codes 0xC-0xF carry no meaning and are dropped everywhere.
   function automatic logic es_tecla_util(input logic [3:0] t);
      return (t <= TECLA_ENVIAR);
   endfunction

endpackage

// File: rtl/pin_teclado_temporizador.sv
// ----------------------------------------------------------------------------
// temporizador_tecla
// Idle counter for a partially entered PIN. Counts up from 0 while enabled,
// saturates at all-ones, and flags when it sits at TIMEOUT-1.
//   Clk       : clock
//   Reset     : synchronous active-high reset
//   limpiar   : force count back to 0 (has priority over habilitar)
//   habilitar : count one per cycle
//   expiro    : count equals TIMEOUT-1
// ----------------------------------------------------------------------------
module temporizador_tecla #(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic Clk,
   input  logic Reset,
   input  logic limpiar,
   input  logic habilitar,
   output logic expiro
);

   localparam logic [7:0] LIMITE = TIMEOUT - 8'd1;

   logic [7:0] cuenta_q, cuenta_d;

   always_comb begin
      cuenta_d = cuenta_q;
      if (limpiar) begin
         cuenta_d = 8'd0;
      end else if (habilitar && (cuenta_q != 8'hFF)) begin
         cuenta_d = cuenta_q + 8'd1;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         cuenta_q <= 8'd0;
      end else begin
         cuenta_q <= cuenta_d;
      end
   end

   assign expiro = (cuenta_q == LIMITE);

endmodule

// File: rtl/pin_teclado.sv
// ----------------------------------------------------------------------------
// pin_teclado
// Two-digit PIN entry from a keypad. Digits are buffered as BCD, ENVIAR
// presents the PIN on Pin for one cycle, invalid submissions pulse Error and
// an abandoned partial entry is discarded after TIMEOUT idle cycles.
//   Clk          : clock
//   Reset        : synchronous active-high reset
//   Tecla_valida : one-cycle strobe qualifying Tecla
//   Tecla        : key code (0-9 digit, A BORRAR, B ENVIAR, C-F unused)
//   Pin          : {first, second} digit for one cycle after ENVIAR, else 0
//   Digitos      : number of digits buffered
//   Error        : pulse on rejected ENVIAR
//   Expirado     : pulse when a partial entry times out
//
// state    | meaning
// ESPERA   | no digits buffered
// DIGITO1  | first digit in high nibble
// COMPLETO | both digits buffered, further digits ignored
// ENVIO    | Pin presented this cycle, keys dropped
// ----------------------------------------------------------------------------
module pin_teclado
   import pin_teclado_pkg::*;
#(
   parameter logic [7:0] TIMEOUT = 8'd200
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Tecla_valida,
   input  logic [3:0] Tecla,
   output logic [7:0] Pin,
   output logic [1:0] Digitos,
   output logic       Error,
   output logic       Expirado
);

   estado_t    estado_q, estado_d;
   logic [7:0] buf_q, buf_d;
   logic [7:0] pin_q;
   logic       error_q, error_d;
   logic       expir_q, expir_d;

   logic acepta;
   logic activo;
   logic expiro;

   assign acepta = Tecla_valida && es_tecla_util(Tecla);
   assign activo = (estado_q == DIGITO1) || (estado_q == COMPLETO);

   // expir_d only rises while active and no key was taken, so clearing on it
   // keeps the count at 0 from the first ESPERA cycle on.
   temporizador_tecla #(
      .TIMEOUT   (TIMEOUT)
   ) u_temporizador (
      .Clk       (Clk),
      .Reset     (Reset),
      .limpiar   (acepta || !activo || expir_d),
      .habilitar (activo),
      .expiro    (expiro)
   );

   always_comb begin
      estado_d = estado_q;
      buf_d    = buf_q;
      error_d  = 1'b0;
      expir_d  = 1'b0;
      unique case (estado_q)
         ESPERA: begin
            if (acepta) begin
               if (es_digito(Tecla)) begin
                  buf_d    = {Tecla, 4'h0};
                  estado_d = DIGITO1;
               end else if (Tecla == TECLA_ENVIAR) begin
                  error_d = 1'b1;
                  buf_d   = PIN_ESPERA;
               end
            end
         end
         DIGITO1: begin
            if (acepta) begin
               if (es_digito(Tecla)) begin
                  buf_d[3:0] = Tecla;
                  estado_d   = COMPLETO;
               end else begin
                  error_d  = (Tecla == TECLA_ENVIAR);
                  buf_d    = PIN_ESPERA;
                  estado_d = ESPERA;
               end
            end else if (expiro) begin
               expir_d  = 1'b1;
               buf_d    = PIN_ESPERA;
               estado_d = ESPERA;
            end
         end
         COMPLETO: begin
            if (acepta) begin
               if (Tecla == TECLA_BORRAR) begin
                  buf_d    = PIN_ESPERA;
                  estado_d = ESPERA;
               end else if (Tecla == TECLA_ENVIAR) begin
                  if (buf_q != PIN_ESPERA) begin
                     estado_d = ENVIO;
                  end else begin
                     error_d  = 1'b1;
                     buf_d    = PIN_ESPERA;
                     estado_d = ESPERA;
                  end
               end
            end else if (expiro) begin
               expir_d  = 1'b1;
               buf_d    = PIN_ESPERA;
               estado_d = ESPERA;
            end
         end
         ENVIO: begin
            buf_d    = PIN_ESPERA;
            estado_d = ESPERA;
         end
         default: begin
            buf_d    = PIN_ESPERA;
            estado_d = ESPERA;
         end
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         estado_q <= ESPERA;
         buf_q    <= PIN_ESPERA;
         pin_q    <= PIN_ESPERA;
         error_q  <= 1'b0;
         expir_q  <= 1'b0;
      end else begin
         estado_q <= estado_d;
         buf_q    <= buf_d;
         pin_q    <= (estado_d == ENVIO) ? buf_d : PIN_ESPERA;
         error_q  <= error_d;
         expir_q  <= expir_d;
      end
   end

   assign Pin      = pin_q;
   assign Error    = error_q;
   assign Expirado = expir_q;
   assign Digitos  = (estado_q == DIGITO1)  ? 2'd1 :
                     (estado_q == COMPLETO) ? 2'd2 : 2'd0;

endmodule

// File: tb/tb_pin_teclado.sv
module tb_pin_teclado;

   localparam logic [7:0] T = 8'd12;
   localparam logic [3:0] BOR = 4'hA;
   localparam logic [3:0] ENV = 4'hB;

   logic       Clk = 1'b0;
   logic       Reset;
   logic       Tecla_valida;
   logic [3:0] Tecla;
   logic [7:0] Pin;
   logic [1:0] Digitos;
   logic       Error;
   logic       Expirado;

   int compared   = 0;
   int mismatched = 0;
   int ciclo      = 0;

   typedef struct {
      logic [7:0] pin;
      logic       err;
      logic       exp;
      int         ciclo;
   } evento_t;

   evento_t cola[$];

   pin_teclado #(.TIMEOUT(T)) dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .Tecla_valida (Tecla_valida),
      .Tecla        (Tecla),
      .Pin          (Pin),
      .Digitos      (Digitos),
      .Error        (Error),
      .Expirado     (Expirado)
   );

   always #5 Clk = ~Clk;

   always @(posedge Clk) ciclo <= ciclo + 1;

   // Monitor: every non-idle output cycle must match the head of the queue.
   always @(negedge Clk) begin
      if (cola.size() > 0 && cola[0].ciclo < ciclo) begin
         compared++;
         mismatched++;
         $display("FAIL missed_event: expected pin=%h err=%b exp=%b at cycle %0d, nothing seen by cycle %0d",
                  cola[0].pin, cola[0].err, cola[0].exp, cola[0].ciclo, ciclo);
         void'(cola.pop_front());
      end
      if (Pin != 8'h00 || Error || Expirado) begin
         compared++;
         if (cola.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: cycle %0d got pin=%h err=%b exp=%b, required idle",
                     ciclo, Pin, Error, Expirado);
         end else begin
            evento_t e;
            e = cola.pop_front();
            if (Pin !== e.pin || Error !== e.err || Expirado !== e.exp || ciclo != e.ciclo) begin
               mismatched++;
               $display("FAIL event: got pin=%h err=%b exp=%b cycle %0d, required pin=%h err=%b exp=%b cycle %0d",
                        Pin, Error, Expirado, ciclo, e.pin, e.err, e.exp, e.ciclo);
            end
         end
      end
   end

   task automatic ciclos(input int n);
      repeat (n) begin
         @(posedge Clk);
         #1;
      end
   endtask

   task automatic tecla(input logic [3:0] k);
      Tecla_valida = 1'b1;
      Tecla        = k;
      @(posedge Clk);
      #1;
      Tecla_valida = 1'b0;
      Tecla        = 4'h0;
   endtask

   task automatic espera(input logic [7:0] pin, input logic err, input logic exp, input int c);
      evento_t e;
      e.pin = pin; e.err = err; e.exp = exp; e.ciclo = c;
      cola.push_back(e);
   endtask

   task automatic chk(input string nombre, input logic [7:0] got, input logic [7:0] req);
      compared++;
      if (got !== req) begin
         mismatched++;
         $display("FAIL %s: got %h, required %h", nombre, got, req);
      end
   endtask

   initial begin
      Reset        = 1'b1;
      Tecla_valida = 1'b1;
      Tecla        = 4'h5;
      ciclos(3);
      chk("reset_pin", Pin, 8'h00);
      chk("reset_digitos", {6'd0, Digitos}, 8'd0);
      chk("reset_error", {7'd0, Error}, 8'd0);
      chk("reset_expirado", {7'd0, Expirado}, 8'd0);
      Tecla_valida = 1'b0;
      Reset        = 1'b0;
      ciclos(2);

      // 0,8,ENVIAR -> 08 one cycle after ENVIAR
      tecla(4'h0); chk("d1_digitos", {6'd0, Digitos}, 8'd1);
      tecla(4'h8); chk("d2_digitos", {6'd0, Digitos}, 8'd2);
      tecla(ENV);  espera(8'h08, 1'b0, 1'b0, ciclo);
      ciclos(1);   chk("after_envio_digitos", {6'd0, Digitos}, 8'd0);
      ciclos(2);

      // 3,ENVIAR -> Error
      tecla(4'h3);
      tecla(ENV);  espera(8'h00, 1'b1, 1'b0, ciclo);
      chk("err1_digitos", {6'd0, Digitos}, 8'd0);
      ciclos(2);

      // 1,2,7,ENVIAR -> 12, third digit ignored
      tecla(4'h1); tecla(4'h2); tecla(4'h7);
      chk("third_digit_digitos", {6'd0, Digitos}, 8'd2);
      tecla(ENV);  espera(8'h12, 1'b0, 1'b0, ciclo);
      ciclos(2);

      // Timeout expiry
      tecla(4'h5);
      espera(8'h00, 1'b0, 1'b1, ciclo + int'(T));
      ciclos(int'(T) + 1);
      chk("expiry_digitos", {6'd0, Digitos}, 8'd0);
      ciclos(2);

      // Key in the cycle the count reaches TIMEOUT-1 wins over expiry
      tecla(4'h5);
      ciclos(int'(T) - 1);
      tecla(4'h6);
      chk("late_key_digitos", {6'd0, Digitos}, 8'd2);
      ciclos(3);
      chk("late_key_hold", {6'd0, Digitos}, 8'd2);
      tecla(BOR);
      chk("borrar_digitos", {6'd0, Digitos}, 8'd0);
      ciclos(2);

      // 0,0,ENVIAR -> Error, Pin never non-zero
      tecla(4'h0); tecla(4'h0);
      tecla(ENV);  espera(8'h00, 1'b1, 1'b0, ciclo);
      ciclos(2);

      // Unused codes and BORRAR in ESPERA do nothing; ENVIAR in ESPERA errors
      tecla(4'hC); tecla(4'hF); tecla(BOR);
      chk("unused_digitos", {6'd0, Digitos}, 8'd0);
      tecla(4'h9); tecla(4'hD);
      chk("unused_d1_digitos", {6'd0, Digitos}, 8'd1);
      tecla(BOR);
      tecla(ENV);  espera(8'h00, 1'b1, 1'b0, ciclo);
      ciclos(2);

      // Key during ENVIO is dropped
      tecla(4'h4); tecla(4'h2);
      tecla(ENV);  espera(8'h42, 1'b0, 1'b0, ciclo);
      tecla(4'h5);
      chk("envio_drop_digitos", {6'd0, Digitos}, 8'd0);
      ciclos(2);

      // 4,6,BORRAR,0,8,ENVIAR -> 08, reset during ENVIO
      tecla(4'h4); tecla(4'h6); tecla(BOR);
      chk("borrar2_digitos", {6'd0, Digitos}, 8'd0);
      tecla(4'h0); tecla(4'h8);
      tecla(ENV);  espera(8'h08, 1'b0, 1'b0, ciclo);
      Reset = 1'b1;
      ciclos(1);
      chk("reset_in_envio_pin", Pin, 8'h00);
      Reset = 1'b0;
      ciclos(3);

      compared++;
      if (cola.size() != 0) begin
         mismatched++;
         $display("FAIL leftover_events: got %0d pending, required 0", cola.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
